// File: rtl/timeclock_if.sv
// Button inputs and time/status outputs of the time-keeping core.
// The master side drives the buttons; the slave side is the core.
interface timeclock_if;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_set;
    logic       i_btn_inc;
    logic [5:0] o_hour;
    logic [5:0] o_min;
    logic [5:0] o_sec;
    logic [6:0] o_msec;
    logic [1:0] o_state;
    logic       o_tick;
    logic       o_day_pulse;
    logic       o_fndDP;

    modport master (
        output i_btn_run, i_btn_clear, i_btn_set, i_btn_inc,
        input  o_hour, o_min, o_sec, o_msec, o_state, o_tick, o_day_pulse, o_fndDP
    );

    modport slave (
        input  i_btn_run, i_btn_clear, i_btn_set, i_btn_inc,
        output o_hour, o_min, o_sec, o_msec, o_state, o_tick, o_day_pulse, o_fndDP
    );
endinterface

// File: rtl/timeclock_core.sv
// Settable hour:min:sec:msec clock with run/stop/set control, day-rollover
// strobe and decimal-point blink flag. All outputs come straight from flops.
module timeclock_core #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned HOUR_MOD    = 24,
    parameter bit          AUTO_RUN    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    timeclock_if.slave  io_bus
);
    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] ST_STOP     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_SET_HOUR = 2'd2;
    localparam logic [1:0] ST_SET_MIN  = 2'd3;

    logic [1:0]       r_state, w_state;
    logic [PRE_W-1:0] r_pre,   w_pre;
    logic [5:0]       r_hour,  w_hour;
    logic [5:0]       r_min,   w_min;
    logic [5:0]       r_sec,   w_sec;
    logic [6:0]       r_msec,  w_msec;
    logic             r_tick,  w_tick;
    logic             r_day,   w_day;
    logic             r_dp,    w_dp;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= AUTO_RUN ? ST_RUN : ST_STOP;
            r_pre   <= '0;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_msec  <= '0;
            r_tick  <= 1'b0;
            r_day   <= 1'b0;
            r_dp    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_hour  <= w_hour;
            r_min   <= w_min;
            r_sec   <= w_sec;
            r_msec  <= w_msec;
            r_tick  <= w_tick;
            r_day   <= w_day;
            r_dp    <= w_dp;
        end
    end

    // Time advance first, then at most one button (clear > run > set > inc).
    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_hour  = r_hour;
        w_min   = r_min;
        w_sec   = r_sec;
        w_msec  = r_msec;
        w_tick  = 1'b0;
        w_day   = 1'b0;

        if (r_state == ST_RUN) begin
            if (r_pre == PRE_W'(DIV - 1)) begin
                w_pre  = '0;
                w_tick = 1'b1;
                if (r_msec == 7'(TICK_HZ - 1)) begin
                    w_msec = '0;
                    if (r_sec == 6'd59) begin
                        w_sec = '0;
                        if (r_min == 6'd59) begin
                            w_min = '0;
                            if (r_hour == 6'(HOUR_MOD - 1)) begin
                                w_hour = '0;
                                w_day  = 1'b1;
                            end else begin
                                w_hour = r_hour + 6'd1;
                            end
                        end else begin
                            w_min = r_min + 6'd1;
                        end
                    end else begin
                        w_sec = r_sec + 6'd1;
                    end
                end else begin
                    w_msec = r_msec + 7'd1;
                end
            end else begin
                w_pre = r_pre + PRE_W'(1);
            end
        end

        if (io_bus.i_btn_clear) begin
            if (r_state == ST_STOP) begin
                w_hour = '0;
                w_min  = '0;
                w_sec  = '0;
                w_msec = '0;
            end
        end else if (io_bus.i_btn_run) begin
            if (r_state == ST_RUN) begin
                w_state = ST_STOP;
            end else if (r_state == ST_STOP) begin
                w_state = ST_RUN;
                w_pre   = '0;
            end
        end else if (io_bus.i_btn_set) begin
            case (r_state)
                ST_STOP:     w_state = ST_SET_HOUR;
                ST_SET_HOUR: w_state = ST_SET_MIN;
                ST_SET_MIN: begin
                    w_state = ST_STOP;
                    w_sec   = '0;
                    w_msec  = '0;
                end
                default:     w_state = r_state;
            endcase
        end else if (io_bus.i_btn_inc) begin
            if (r_state == ST_SET_HOUR) begin
                w_hour = (r_hour == 6'(HOUR_MOD - 1)) ? 6'd0 : r_hour + 6'd1;
            end else if (r_state == ST_SET_MIN) begin
                w_min = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            end
        end

        w_dp = (w_msec < 7'(TICK_HZ / 2));
    end

    assign io_bus.o_hour      = r_hour;
    assign io_bus.o_min       = r_min;
    assign io_bus.o_sec       = r_sec;
    assign io_bus.o_msec      = r_msec;
    assign io_bus.o_state     = r_state;
    assign io_bus.o_tick      = r_tick;
    assign io_bus.o_day_pulse = r_day;
    assign io_bus.o_fndDP     = r_dp;
endmodule

// File: tb/tb_timeclock_core.sv
// Directed bench for timeclock_core: a 24-hour and a 12-hour instance share
// the same button stimulus; expected values are worked out by hand.
module tb_timeclock_core;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    timeclock_if u_if_a ();
    timeclock_if u_if_b ();

    timeclock_core #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24), .AUTO_RUN(1'b1)
    ) u_dut_a (
        .i_clk(clk), .i_reset(rst), .io_bus(u_if_a)
    );

    timeclock_core #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .HOUR_MOD(12), .AUTO_RUN(1'b1)
    ) u_dut_b (
        .i_clk(clk), .i_reset(rst), .io_bus(u_if_b)
    );

    typedef struct {
        logic [3:0] btn;   // {clear, run, set, inc}
        int         reps;
        int         st;
        int         hr;
        int         hr_b;
        int         mn;
        int         sc;
        int         ms;
        string      name;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [17];

    function automatic vec_t mk(input logic [3:0] btn, input int reps, input int st,
                                input int hr, input int hr_b, input int mn,
                                input int sc, input int ms, input string name);
        vec_t v;
        v.btn = btn; v.reps = reps; v.st = st; v.hr = hr; v.hr_b = hr_b;
        v.mn = mn; v.sc = sc; v.ms = ms; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] b);
        u_if_a.i_btn_clear = b[3]; u_if_a.i_btn_run = b[2];
        u_if_a.i_btn_set   = b[1]; u_if_a.i_btn_inc = b[0];
        u_if_b.i_btn_clear = b[3]; u_if_b.i_btn_run = b[2];
        u_if_b.i_btn_set   = b[1]; u_if_b.i_btn_inc = b[0];
    endtask

    task automatic press(input logic [3:0] b, input int reps);
        drive(b);
        step(reps);
        drive(4'b0000);
    endtask

    task automatic chk_time(input string tag, input int hr, input int mn, input int sc, input int ms);
        chk({tag, " hour"}, int'(u_if_a.o_hour), hr);
        chk({tag, " min"},  int'(u_if_a.o_min),  mn);
        chk({tag, " sec"},  int'(u_if_a.o_sec),  sc);
        chk({tag, " msec"}, int'(u_if_a.o_msec), ms);
    endtask

    initial begin
        vecs[0]  = mk(4'b0010,  1, 2,  0,  0,  0, 1, 2, "stop_to_sethour");
        vecs[1]  = mk(4'b0001, 25, 2,  1,  1,  0, 1, 2, "hour_inc_x25");
        vecs[2]  = mk(4'b0010,  1, 3,  1,  1,  0, 1, 2, "sethour_to_setmin");
        vecs[3]  = mk(4'b0001, 61, 3,  1,  1,  1, 1, 2, "min_inc_x61");
        vecs[4]  = mk(4'b0100,  1, 3,  1,  1,  1, 1, 2, "run_ignored_setmin");
        vecs[5]  = mk(4'b0010,  1, 0,  1,  1,  1, 0, 0, "setmin_to_stop");
        vecs[6]  = mk(4'b0001,  1, 0,  1,  1,  1, 0, 0, "inc_ignored_stop");
        vecs[7]  = mk(4'b1111,  1, 0,  0,  0,  0, 0, 0, "all_buttons_clear_wins");
        vecs[8]  = mk(4'b0010,  1, 2,  0,  0,  0, 0, 0, "enter_sethour");
        vecs[9]  = mk(4'b0001, 23, 2, 23, 11,  0, 0, 0, "hour_inc_x23");
        vecs[10] = mk(4'b0100,  1, 2, 23, 11,  0, 0, 0, "run_ignored_sethour");
        vecs[11] = mk(4'b0010,  1, 3, 23, 11,  0, 0, 0, "enter_setmin");
        vecs[12] = mk(4'b0001, 59, 3, 23, 11, 59, 0, 0, "min_inc_x59");
        vecs[13] = mk(4'b0010,  1, 0, 23, 11, 59, 0, 0, "back_to_stop");
        vecs[14] = mk(4'b0100,  1, 1, 23, 11, 59, 0, 0, "stop_to_run");
        vecs[15] = mk(4'b0010,  1, 1, 23, 11, 59, 0, 0, "set_ignored_run");
        vecs[16] = mk(4'b0001,  1, 1, 23, 11, 59, 0, 0, "inc_ignored_run");

        rst = 1'b1;
        drive(4'b0000);
        step(3);
        chk("reset state", int'(u_if_a.o_state), 1);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset tick", int'(u_if_a.o_tick), 0);
        chk("reset day", int'(u_if_a.o_day_pulse), 0);
        chk("reset dp", int'(u_if_a.o_fndDP), 1);
        chk("reset state b", int'(u_if_b.o_state), 1);
        rst = 1'b0;

        // First advance lands exactly 10 edges after reset release.
        step(9);
        chk("pre-first msec", int'(u_if_a.o_msec), 0);
        chk("pre-first tick", int'(u_if_a.o_tick), 0);
        step(1);
        chk("first msec", int'(u_if_a.o_msec), 1);
        chk("first tick", int'(u_if_a.o_tick), 1);
        step(1);
        chk("tick one cycle", int'(u_if_a.o_tick), 0);
        step(489);
        chk("msec50", int'(u_if_a.o_msec), 50);
        chk("msec50 dp", int'(u_if_a.o_fndDP), 0);
        step(500);
        chk_time("1s", 0, 0, 1, 0);
        chk("1s dp", int'(u_if_a.o_fndDP), 1);

        // Run/stop freeze and restart latency.
        press(4'b0100, 1);
        chk("stop state", int'(u_if_a.o_state), 0);
        step(500);
        chk_time("frozen", 0, 0, 1, 0);
        chk("frozen tick", int'(u_if_a.o_tick), 0);
        press(4'b0100, 1);
        chk("restart state", int'(u_if_a.o_state), 1);
        step(9);
        chk("restart pre msec", int'(u_if_a.o_msec), 0);
        step(1);
        chk("restart msec", int'(u_if_a.o_msec), 1);
        chk("restart tick", int'(u_if_a.o_tick), 1);
        press(4'b1000, 1);
        chk("clear ignored run state", int'(u_if_a.o_state), 1);
        chk_time("clear ignored run", 0, 0, 1, 1);
        step(8);
        // Stop on the same edge as a prescaler wrap: time still advances.
        press(4'b0100, 1);
        chk("wrap+stop state", int'(u_if_a.o_state), 0);
        chk("wrap+stop msec", int'(u_if_a.o_msec), 2);
        chk("wrap+stop tick", int'(u_if_a.o_tick), 1);
        step(1);
        chk("wrap+stop tick drop", int'(u_if_a.o_tick), 0);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].btn, vecs[i].reps);
            chk({vecs[i].name, " state"}, int'(u_if_a.o_state), vecs[i].st);
            chk({vecs[i].name, " hour"},  int'(u_if_a.o_hour),  vecs[i].hr);
            chk({vecs[i].name, " hour_b"}, int'(u_if_b.o_hour), vecs[i].hr_b);
            chk({vecs[i].name, " min"},   int'(u_if_a.o_min),   vecs[i].mn);
            chk({vecs[i].name, " sec"},   int'(u_if_a.o_sec),   vecs[i].sc);
            chk({vecs[i].name, " msec"},  int'(u_if_a.o_msec),  vecs[i].ms);
        end

        // Prescaler sits at 2 here: 5999 advances need 59997 edges.
        step(59997);
        chk_time("pre-rollover", 23, 59, 59, 99);
        chk("pre-rollover hour_b", int'(u_if_b.o_hour), 11);
        chk("pre-rollover dp", int'(u_if_a.o_fndDP), 0);
        chk("pre-rollover day", int'(u_if_a.o_day_pulse), 0);
        step(1);
        chk_time("rollover", 0, 0, 0, 0);
        chk("rollover tick", int'(u_if_a.o_tick), 1);
        chk("rollover day", int'(u_if_a.o_day_pulse), 1);
        chk("rollover hour_b", int'(u_if_b.o_hour), 0);
        chk("rollover min_b", int'(u_if_b.o_min), 0);
        chk("rollover day_b", int'(u_if_b.o_day_pulse), 1);
        step(1);
        chk("day drop", int'(u_if_a.o_day_pulse), 0);
        chk("day drop b", int'(u_if_b.o_day_pulse), 0);
        chk("tick drop", int'(u_if_a.o_tick), 0);

        // Reset in the middle of SET_MIN at 12:34.
        press(4'b0100, 1);
        press(4'b0010, 1);
        press(4'b0001, 12);
        press(4'b0010, 1);
        press(4'b0001, 34);
        chk("setmin state", int'(u_if_a.o_state), 3);
        chk("setmin hour", int'(u_if_a.o_hour), 12);
        chk("setmin min", int'(u_if_a.o_min), 34);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid-set reset state", int'(u_if_a.o_state), 1);
        chk_time("mid-set reset", 0, 0, 0, 0);
        chk("mid-set reset dp", int'(u_if_a.o_fndDP), 1);
        chk("mid-set reset tick", int'(u_if_a.o_tick), 0);
        chk("mid-set reset state b", int'(u_if_b.o_state), 1);
        step(9);
        chk("post-reset pre tick", int'(u_if_a.o_tick), 0);
        step(1);
        chk("post-reset msec", int'(u_if_a.o_msec), 1);
        chk("post-reset tick", int'(u_if_a.o_tick), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/timeclock_core.md
# timeclock_core

Parametrised, settable hour:min:sec:msec time-keeping core with run/stop and time-set control. It replaces the fixed clock divider and time counter pair that feeds the digit dividers and FND mux chain, adding a configurable tick rate and hour modulus. It also adds button-driven run/stop/clear/set behaviour, a day-rollover strobe and a blink flag for the FND decimal point. Display scanning, digit splitting and font decoding stay downstream and unchanged.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, msec-field increment rate; DIV = CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2.
- HOUR_MOD, 24, hour modulus; legal values are 12 and 24, and hour counts 0..HOUR_MOD-1.
- AUTO_RUN, 1, state after reset: 1 = RUN, 0 = STOP.
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_btn_run  in  1  single-cycle pulse (pre-debounced); toggles RUN/STOP.
- i_btn_clear  in  1  pulse; zeroes time, honoured in STOP only.
- i_btn_set  in  1  pulse; steps STOP→SET_HOUR→SET_MIN→STOP.
- i_btn_inc  in  1  pulse; increments the field being set.
- o_hour  out  6  hours, binary.
- o_min  out  6  minutes 0..59.
- o_sec  out  6  seconds 0..59.
- o_msec  out  7  hundredths 0..TICK_HZ-1.
- o_state  out  2  0 = STOP, 1 = RUN, 2 = SET_HOUR, 3 = SET_MIN.
- o_tick  out  1  one-cycle strobe when the time value advances in RUN.
- o_day_pulse  out  1  one-cycle strobe on full rollover to 00:00:00.00.
- o_fndDP  out  1  1 when o_msec < TICK_HZ/2, else 0.

## Operation
- Prescaler counts 0..DIV-1 in RUN only and holds in all other states. On reaching DIV-1 it wraps to 0 and the time advances by one msec.
- Carry chain: msec wraps TICK_HZ-1→0 and carries to sec. Sec wraps 59→0 and carries to min. Min wraps 59→0 and carries to hour. Hour wraps HOUR_MOD-1→0. A carry out of hour raises o_day_pulse.
- FSM transitions:
  - RUN --btn_run--> STOP.
  - STOP --btn_run--> RUN; the prescaler is cleared on this edge.
  - STOP --btn_set--> SET_HOUR --btn_set--> SET_MIN --btn_set--> STOP; sec and msec are zeroed on the SET_MIN→STOP edge.
  - SET_HOUR and SET_MIN ignore btn_run.
- btn_inc in SET_HOUR: hour+1 mod HOUR_MOD, with no carry. In SET_MIN: min+1 mod 60, with no carry to hour. btn_inc is ignored in RUN and STOP.
- btn_clear in STOP: hour, min, sec and msec go to 0. btn_clear is ignored elsewhere.
- Simultaneous pulses: priority is clear > run > set > inc. At most one button is acted on per cycle, and the rest are dropped.
- A button pulse in the same cycle as a prescaler wrap in RUN: the time advances and btn_run takes effect on the same edge. The resulting STOP state shows the advanced time.

## Timing
- Reset values: all time outputs 0; prescaler 0; o_tick and o_day_pulse 0; o_fndDP 1; o_state = 1 if AUTO_RUN else 0.
- Reset has priority over every button and overrides the state mid-count or mid-set on the same edge.
- Starting from prescaler 0 in RUN, the first advance appears after exactly DIV clock edges. Thereafter one advance occurs every DIV cycles.
- o_tick and o_day_pulse are registered. Each is high for exactly one cycle: the first cycle in which the new time is visible on the outputs.
- Button effects (state, field values) are visible one cycle after the pulse is sampled, with 1-cycle latency.
- o_fndDP is derived from the registered o_msec. It is valid in the same cycle as o_msec, with no additional latency.

## Test plan
- Use CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10), AUTO_RUN=1. Release reset → o_state=1; first o_tick 10 cycles later with o_msec=1; after 1000 cycles o_sec=1 and o_msec=0.
- Force the time to 23:59:59.99 via set/inc, then run → next advance gives 00:00:00.00, o_tick=1 and o_day_pulse=1 for one cycle only. Repeat with HOUR_MOD=12 from 11:59:59.99 → 00.
- Press btn_run while running → STOP and the time freezes for 500 cycles. Press btn_run again → the next advance occurs exactly 10 cycles later.
- In STOP, press btn_set → SET_HOUR, then btn_inc ×25 (HOUR_MOD=24) → o_hour=1. Press btn_set → SET_MIN, then btn_inc ×61 → o_min=1, o_hour unchanged. Press btn_set → STOP with o_sec=0 and o_msec=0.
- Simultaneously pulse clear+run+set+inc in STOP → only clear acts: time = 0, o_state stays 0. Pulse clear in RUN → ignored.
- Assert i_reset for 1 cycle while in SET_MIN at 12:34 → all fields 0, o_fndDP=1, o_state returns to AUTO_RUN value, no o_tick in the reset cycle.
